counter_modulo_chain: RTL



---
 rtl/counter_pkg.sv | 7 +
 rtl/counter_modulo_stage.sv | 24 ++
 rtl/counter_modulo_chain.sv | 51 +++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction type and digit-width helper for the modulo counter chain.
package counter_pkg;
   typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;
   function automatic int clog2_min1(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/counter_modulo_stage.sv
// counter_modulo_stage: one modulo-MOD up/down digit with clamped load, clear and terminal flag.
module counter_modulo_stage import counter_pkg::*; #(
   parameter int MOD = 10,
   parameter int W = clog2_min1(MOD)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] ld_val,
   input  logic         clr,
   input  logic         step,
   input  logic         op,
   output logic [W-1:0] digit,
   output logic         tc
);
   localparam logic [W-1:0] MAX = W'(MOD - 1);
   assign tc = (op == CNT_UP) ? (digit == MAX) : (digit == '0);
   // tc doubles as the wrap condition, so the digit never leaves 0..MOD-1
   always_ff @(posedge clk or negedge rst)
      if (!rst) digit <= '0;
      else if (load) digit <= (ld_val > MAX) ? MAX : ld_val;
      else if (clr) digit <= '0;
      else if (step) digit <= (op == CNT_UP) ? (tc ? '0 : digit + 1'b1) : (tc ? MAX : digit - 1'b1);
endmodule

// File: rtl/counter_modulo_chain.sv
// counter_modulo_chain: NUM_STAGES cascaded modulo-MOD digits with ripple enable and wrap pulse.
// Define COUNTER_CHAIN_SAT_EN to saturate at the terminal value instead of wrapping.
module counter_modulo_chain import counter_pkg::*; #(
   parameter int NUM_STAGES = 4,
   parameter int MOD = 10,
   parameter int W = clog2_min1(MOD)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enb,
   input  logic                    sync_rst_enb,
   input  logic                    op,
   input  logic                    load,
   input  logic [NUM_STAGES*W-1:0] load_value,
   output logic [NUM_STAGES*W-1:0] Counting,
   output logic [NUM_STAGES-1:0]   stage_tc,
   output logic                    Flag,
   output logic                    carry
);
   logic [NUM_STAGES-1:0] ripple;
   logic clr, go;
   assign clr = enb & sync_rst_enb;
   assign Flag = &stage_tc;
`ifdef COUNTER_CHAIN_SAT_EN
   assign go = enb & ~Flag;
`else
   assign go = enb;
`endif
   for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      if (i == 0) begin : g_lsb
         assign ripple[i] = 1'b1;
      end else begin : g_upper
         assign ripple[i] = ripple[i-1] & stage_tc[i-1];
      end
      counter_modulo_stage #(.MOD(MOD), .W(W)) u_stage (
         .clk(clk),
         .rst(rst),
         .load(load),
         .ld_val(load_value[i*W +: W]),
         .clr(clr),
         .step(go & ripple[i]),
         .op(op),
         .digit(Counting[i*W +: W]),
         .tc(stage_tc[i])
      );
   end
   // A step taken while the whole chain is terminal is a wrap (or a saturation hit)
   always_ff @(posedge clk or negedge rst)
      if (!rst) carry <= 1'b0;
      else carry <= ~load & ~clr & enb & Flag;
endmodule
